// File: rtl/crt_pkg.sv
// Shared CRT lane constants and the sequencer state encoding.
package crt_pkg;

    localparam int unsigned NUM_CRT_CONST = 6;
    localparam int unsigned CRT_ROM_AW    = 3;
    localparam int unsigned CRT_CONST_W   = 30;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } crt_state_e;

endpackage

// File: rtl/crt_const_sequencer.sv
// Walks (coefficient, constant) tuples for one CRT lane, driving the crt_rom and
// residue RAM reads and a 1-cycle-delayed valid/first/last framing for the MAC.
module crt_const_sequencer
    import crt_pkg::*;
#(
    parameter int unsigned N_COEFF   = 4096,
    parameter int unsigned COEFF_AW  = 12,
    parameter int unsigned NUM_CONST = NUM_CRT_CONST
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  hold,
    output logic [CRT_ROM_AW-1:0] rom_addr,
    output logic                  mem_rd_en,
    output logic [COEFF_AW-1:0]   mem_rd_addr,
    output logic                  mac_valid,
    output logic                  mac_first,
    output logic                  mac_last,
    output logic [COEFF_AW-1:0]   mac_coeff,
    output logic                  busy,
    output logic                  done
);

    localparam logic [CRT_ROM_AW-1:0] K_LAST = CRT_ROM_AW'(NUM_CONST - 1);
    localparam logic [COEFF_AW-1:0]   C_LAST = COEFF_AW'(N_COEFF - 1);

    crt_state_e              state_q, state_d;
    logic [CRT_ROM_AW-1:0]   k_q;
    logic [COEFF_AW-1:0]     c_q;
    logic                    vld_q, first_q, last_q;
    logic [COEFF_AW-1:0]     coeff_q;
    logic                    issue;
    logic                    k_last, c_last;

    assign k_last = (k_q == K_LAST);
    assign c_last = (c_q == C_LAST);

    // State register; hold freezes the FSM in every state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else if (!hold) begin
            state_q <= state_d;
        end
    end

    // Next state and hold-gated outputs.
    always_comb begin
        state_d   = state_q;
        issue     = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        mem_rd_en = 1'b0;
        mac_valid = 1'b0;
        mac_first = 1'b0;
        mac_last  = 1'b0;
        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (start) state_d = S_RUN;
            end
            S_RUN: begin
                issue = !hold;
                if (k_last && c_last) state_d = S_DRAIN;
            end
            S_DRAIN: state_d = S_DONE;
            S_DONE: begin
                done    = !hold;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        mem_rd_en = issue;
        mac_valid = vld_q && !hold;
        mac_first = first_q && !hold;
        mac_last  = last_q && !hold;
    end

    // Tuple counters: k minor, c major; both return to 0 after the final tuple.
    always_ff @(posedge clk) begin
        if (rst) begin
            k_q <= '0;
            c_q <= '0;
        end else if (issue) begin
            if (k_last) begin
                k_q <= '0;
                c_q <= c_last ? '0 : c_q + COEFF_AW'(1);
            end else begin
                k_q <= k_q + CRT_ROM_AW'(1);
            end
        end
    end

    // Framing stage aligned with the RAM read latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q   <= 1'b0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
            coeff_q <= '0;
        end else if (!hold) begin
            vld_q   <= issue;
            first_q <= issue && (k_q == '0);
            last_q  <= issue && k_last;
            if (issue) coeff_q <= c_q;
        end
    end

    assign rom_addr    = k_q;
    assign mem_rd_addr = c_q;
    assign mac_coeff   = coeff_q;

endmodule

// File: tb/tb_crt_const_sequencer.sv
// Directed bench for crt_const_sequencer: small (N=4), full-size and N=1/K=1 instances.
module tb_crt_const_sequencer;

    logic clk, rst, hold;
    logic [2:0] st;

    int checks   = 0;
    int failures = 0;

    logic [2:0]  rom4, romf, rom1;
    logic        rd4, rdf, rd1;
    logic [1:0]  rda4;
    logic [11:0] rdaf;
    logic [0:0]  rda1;
    logic        mv4, mf4, ml4, mvf, mff, mlf, mv1, mf1, ml1;
    logic [1:0]  mc4;
    logic [11:0] mcf;
    logic [0:0]  mc1;
    logic        busy4, busyf, busy1, dn4, dnf, dn1;

    crt_const_sequencer #(.N_COEFF(4), .COEFF_AW(2), .NUM_CONST(6)) u_dut4 (
        .clk(clk), .rst(rst), .start(st[0]), .hold(hold),
        .rom_addr(rom4), .mem_rd_en(rd4), .mem_rd_addr(rda4),
        .mac_valid(mv4), .mac_first(mf4), .mac_last(ml4), .mac_coeff(mc4),
        .busy(busy4), .done(dn4));

    crt_const_sequencer #(.N_COEFF(4096), .COEFF_AW(12), .NUM_CONST(6)) u_dutf (
        .clk(clk), .rst(rst), .start(st[1]), .hold(hold),
        .rom_addr(romf), .mem_rd_en(rdf), .mem_rd_addr(rdaf),
        .mac_valid(mvf), .mac_first(mff), .mac_last(mlf), .mac_coeff(mcf),
        .busy(busyf), .done(dnf));

    crt_const_sequencer #(.N_COEFF(1), .COEFF_AW(1), .NUM_CONST(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(st[2]), .hold(hold),
        .rom_addr(rom1), .mem_rd_en(rd1), .mem_rd_addr(rda1),
        .mac_valid(mv1), .mac_first(mf1), .mac_last(ml1), .mac_coeff(mc1),
        .busy(busy1), .done(dn1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One cycle: drive inputs just after the rising edge, return at the falling edge.
    task automatic cyc(input logic [2:0] s, input logic h, input logic r);
        @(posedge clk);
        #1;
        st   = s;
        hold = h;
        rst  = r;
        @(negedge clk);
    endtask

    // Run on the N=4 instance with start in cycle T; holds over cycles [hs, hs+hl);
    // a stray start in cycle T+sx. Per-cycle expectations come from a tuple scoreboard.
    task automatic run4(input int hs, input int hl, input int sx, input int nmax,
                        output int done_at, output int ndone, output int ntup);
        int   iss, vidx, bs;
        logic vpend, h;
        iss = 0; vidx = 0; bs = 1; vpend = 1'b0;
        done_at = -1; ndone = 0; ntup = 0;
        cyc(3'b001, 1'b0, 1'b0);
        for (int n = 1; n <= nmax; n++) begin
            h = (n >= hs) && (n < hs + hl);
            cyc((n == sx) ? 3'b001 : 3'b000, h, 1'b0);
            chk("busy", 32'(busy4), 32'(bs != 0));
            chk("mem_rd_en", 32'(rd4), 32'(bs == 1 && !h));
            if (bs == 1) begin
                chk("rom_addr", 32'(rom4), 32'(iss % 6));
                chk("mem_rd_addr", 32'(rda4), 32'(iss / 6));
            end
            chk("mac_valid", 32'(mv4), 32'(vpend && !h));
            if (vpend) begin
                chk("mac_first", 32'(mf4), 32'(!h && (vidx % 6 == 0)));
                chk("mac_last", 32'(ml4), 32'(!h && (vidx % 6 == 5)));
                chk("mac_coeff", 32'(mc4), 32'(vidx / 6));
            end
            chk("done", 32'(dn4), 32'(bs == 3 && !h));
            if (dn4 === 1'b1) begin
                ndone++;
                if (done_at < 0) done_at = n;
            end
            if (mv4 === 1'b1) ntup++;
            if (!h) begin
                vpend = (bs == 1);
                vidx  = iss;
                case (bs)
                    1: begin iss++; if (iss == 24) bs = 2; end
                    2: bs = 3;
                    default: bs = 0;
                endcase
            end
        end
    endtask

    initial begin
        int da, nd, nt, d2, bad, lastc, ntf, daf;
        st = 3'b000; hold = 1'b0; rst = 1'b1;

        // Reset state
        cyc(3'b000, 1'b0, 1'b1);
        cyc(3'b000, 1'b0, 1'b1);
        chk("rst_busy", 32'(busy4), 32'd0);
        chk("rst_rom_addr", 32'(rom4), 32'd0);
        chk("rst_mac_valid", 32'(mv4), 32'd0);
        chk("rst_done", 32'(dn4), 32'd0);
        chk("rst_busy_full", 32'(busyf), 32'd0);
        cyc(3'b000, 1'b0, 1'b0);

        // Basic run: done at T+26 only
        run4(0, 0, 0, 27, da, nd, nt);
        chk("basic_done_cycle", 32'(da), 32'd26);
        chk("basic_done_count", 32'(nd), 32'd1);
        chk("basic_tuples", 32'(nt), 32'd24);

        // Hold on issue (c=1,k=2), i.e. cycle T+9, for 3 cycles: done at T+29
        run4(9, 3, 0, 30, da, nd, nt);
        chk("hold_done_cycle", 32'(da), 32'd29);
        chk("hold_tuples", 32'(nt), 32'd24);

        // Stray start at T+5 ignored; restart in the first IDLE cycle T+27
        run4(0, 0, 5, 26, da, nd, nt);
        chk("busy_start_done_cycle", 32'(da), 32'd26);
        chk("busy_start_done_count", 32'(nd), 32'd1);
        run4(0, 0, 0, 27, d2, nd, nt);
        chk("restart_done_abs", 32'(d2 + 27), 32'd53);
        chk("restart_tuples", 32'(nt), 32'd24);

        // start together with hold in IDLE is dropped
        cyc(3'b001, 1'b1, 1'b0);
        cyc(3'b000, 1'b0, 1'b0);
        chk("start_hold_idle_busy", 32'(busy4), 32'd0);
        cyc(3'b000, 1'b0, 1'b0);
        chk("start_hold_idle_busy2", 32'(busy4), 32'd0);

        // Reset in cycle T+10 abandons the run
        cyc(3'b001, 1'b0, 1'b0);
        for (int n = 1; n <= 9; n++) cyc(3'b000, 1'b0, 1'b0);
        chk("pre_rst_busy", 32'(busy4), 32'd1);
        cyc(3'b000, 1'b0, 1'b1);
        cyc(3'b000, 1'b0, 1'b0);
        chk("mid_rst_busy", 32'(busy4), 32'd0);
        chk("mid_rst_rom_addr", 32'(rom4), 32'd0);
        chk("mid_rst_rd_addr", 32'(rda4), 32'd0);
        chk("mid_rst_rd_en", 32'(rd4), 32'd0);
        chk("mid_rst_mac_valid", 32'(mv4), 32'd0);
        chk("mid_rst_mac_coeff", 32'(mc4), 32'd0);
        chk("mid_rst_done", 32'(dn4), 32'd0);
        nd = 0;
        for (int n = 0; n < 20; n++) begin
            cyc(3'b000, 1'b0, 1'b0);
            if (dn4 !== 1'b0) nd++;
        end
        chk("mid_rst_no_done", 32'(nd), 32'd0);
        run4(0, 0, 0, 27, da, nd, nt);
        chk("post_rst_done_cycle", 32'(da), 32'd26);
        chk("post_rst_tuples", 32'(nt), 32'd24);

        // Full-size run
        bad = 0; lastc = -1; ntf = 0; daf = -1;
        cyc(3'b010, 1'b0, 1'b0);
        for (int n = 1; n <= 24580; n++) begin
            cyc(3'b000, 1'b0, 1'b0);
            if (romf >= 3'd6) bad++;
            if (mvf === 1'b1) ntf++;
            if (mvf === 1'b1 && mlf === 1'b1) lastc = int'(mcf);
            if (dnf === 1'b1 && daf < 0) daf = n;
        end
        chk("full_rom_addr_range", 32'(bad), 32'd0);
        chk("full_last_coeff", 32'(lastc), 32'd4095);
        chk("full_tuples", 32'(ntf), 32'd24576);
        chk("full_done_cycle", 32'(daf), 32'd24578);
        chk("full_idle", 32'(busyf), 32'd0);

        // N_COEFF=1, NUM_CONST=1
        cyc(3'b100, 1'b0, 1'b0);
        cyc(3'b000, 1'b0, 1'b0);
        chk("n1_rd_en", 32'(rd1), 32'd1);
        chk("n1_rom_addr", 32'(rom1), 32'd0);
        chk("n1_early_valid", 32'(mv1), 32'd0);
        cyc(3'b000, 1'b0, 1'b0);
        chk("n1_valid", 32'(mv1), 32'd1);
        chk("n1_first", 32'(mf1), 32'd1);
        chk("n1_last", 32'(ml1), 32'd1);
        chk("n1_early_done", 32'(dn1), 32'd0);
        cyc(3'b000, 1'b0, 1'b0);
        chk("n1_done", 32'(dn1), 32'd1);
        chk("n1_valid_off", 32'(mv1), 32'd0);
        cyc(3'b000, 1'b0, 1'b0);
        chk("n1_idle", 32'(busy1), 32'd0);
        chk("n1_done_off", 32'(dn1), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
